// File: rtl/encoder_pkg.sv
// Shared definitions for the N-to-log2(N) request encoder.
//   MODE_FIXED / MODE_RR : values of rr_mode
//   idx_wrap(idx, n)     : successor of idx in the ring 0..n-1
package encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wraps N-1 back to 0. When N is not a power of two this wrap
  // happens before the index width would overflow.
  function automatic int unsigned idx_wrap(int unsigned idx, int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/encoder_n_rr_if.sv
// Request/response bundle for encoder_n_rr.
//   master : drives en, rr_mode, y; observes a, valid, multi
//   slave  : the encoder side
interface encoder_n_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;
  logic         rr_mode;
  logic [N-1:0] y;
  logic [W-1:0] a;
  logic         valid;
  logic         multi;

  modport master (output en, rr_mode, y, input a, valid, multi);
  modport slave  (input en, rr_mode, y, output a, valid, multi);
endinterface

// File: rtl/encoder_rr_pick.sv
// Combinational round-robin pick.
//   y   : request vector
//   ptr : first index to consider (0..N-1)
//   win : first set index at or above ptr, wrapping past N-1 to 0
//   hit : any request present
module encoder_rr_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] y,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         hit
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  // Rotating the doubled vector makes rot[i] = y[(ptr+i) mod N] for any N.
  assign rot = N'({y, y} >> ptr);

  // Lowest set bit of the rotated vector = distance from ptr.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = W'(i);
  end

  // Un-rotate: (ptr + off) mod N, with one extra bit so N=2^W cannot overflow.
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign win = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
  assign hit = |y;

endmodule

// File: rtl/encoder_n_rr.sv
// Registered N-to-log2(N) encoder, fixed-priority or round-robin.
//   clk, rst_n : clock, async active-low reset
//   bus.en     : sample enable
//   bus.rr_mode: 0 = highest index wins, 1 = round-robin from ptr
//   bus.y      : request vector
//   bus.a      : registered winner index (holds when nothing sampled)
//   bus.valid  : one-cycle pulse per sampled non-zero request
//   bus.multi  : sampled request had more than one bit set
module encoder_n_rr
  import encoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  encoder_n_rr_if.slave  bus
);

  localparam int W = $clog2(N);

  logic [W-1:0] ptr, a_q, fix_win, rr_win, win;
  logic         any_req, take, multi_d, valid_q, multi_q;

  encoder_rr_pick #(.N(N)) u_rr_pick (
    .y   (bus.y),
    .ptr (ptr),
    .win (rr_win),
    .hit (any_req)
  );

  // Fixed priority: last assignment in an ascending scan is the highest index.
  always_comb begin
    fix_win = '0;
    for (int i = 0; i < N; i++)
      if (bus.y[i]) fix_win = W'(i);
  end

  assign win     = (bus.rr_mode == MODE_RR) ? rr_win : fix_win;
  assign take    = bus.en & any_req;
  assign multi_d = |(bus.y & (bus.y - N'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= take;
      multi_q <= take & multi_d;
      if (take) begin
        a_q <= win;
        if (bus.rr_mode == MODE_RR)
          ptr <= W'(idx_wrap(32'(rr_win), N));
      end
    end
  end

  assign bus.a     = a_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

endmodule

// File: doc/encoder_n_rr.md
# encoder_n_rr

Parametrised, registered N-to-log2(N) encoder with selectable fixed-priority or round-robin arbitration. Successor to the 4-to-2 behavioral encoder. Each enabled clock it samples an N-bit request vector and registers the winning index, a valid flag and a multi-request flag. It serves as the shared request selector in front of downstream datapaths that need fair or strict-priority selection.

## Interface
- N, 8, number of request inputs; legal range 2..256; need not be a power of two
- W, $clog2(N), localparam, index width; not overridable

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sample enable; request vector ignored when 0
- rr_mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- y  in  N  request vector, bit i = request i
- a  out  W  registered winning index
- valid  out  1  registered; 1 when `a` holds a fresh winner for the sampled cycle
- multi  out  1  registered; 1 when more than one bit of the sampled `y` was set

## Operation
- Reset (rst_n low, asynchronous): a=0, valid=0, multi=0, internal pointer ptr=0. Outputs are held at these values while rst_n is low. Release is synchronous to the next clk edge.
- Cycle with en=0: valid<=0, multi<=0, a holds, ptr holds.
- Cycle with en=1, y==0: valid<=0, multi<=0, a holds, ptr holds.
- Cycle with en=1, y!=0:
  - Fixed mode (rr_mode=0): winner = highest set index. ptr is unchanged.
  - Round-robin mode (rr_mode=1): search upward from ptr: ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The first set bit wins. Then ptr <= winner+1, wrapping from N-1 to 0 (not to 2^W when N is not a power of two).
  - In both modes: a<=winner, valid<=1, multi<=(popcount(y)>1).
- Switching rr_mode between cycles is legal. It takes effect on the next sampled cycle. ptr keeps its value across fixed-mode cycles.
- ptr is always in 0..N-1. No illegal states are reachable.
- y and rr_mode are sampled only when en=1.

## Timing
- Latency is 1 cycle: the response to y sampled at edge k appears on a/valid/multi after edge k and is stable until edge k+1.
- Throughput is one decision per cycle, with no back-pressure.
- valid is a single-cycle pulse per sampled non-zero request. Back-to-back valid cycles are allowed.
- The round-robin pointer update and the output register update occur on the same edge.
- Reset asserted mid-stream clears all state immediately, regardless of clk.
- Combinational path: y → rotated search → a register. It must close at the target clock for N=32.

## Structure
- Shared package encoder_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants
  - function `idx_wrap(idx, N)` for pointer wrap
- Sub-module encoder_rr_pick: purely combinational. Inputs y and ptr. Outputs winner index and a hit bit, using a rotate, then a lowest-set-bit search, then an un-rotate.
- The top module holds:
  - the fixed-priority search
  - the mode mux
  - the popcount>1 detect (a `y & (y-1)` nonzero test is sufficient)
  - ptr, a, valid and multi registers

## Test plan
All scenarios use N=4 unless stated.
- Reset: rst_n=0 with y=4'b1111, en=1 → a=0, valid=0, multi=0 throughout. Release, then fixed mode, y=4'b0100 → one cycle later a=2, valid=1, multi=0.
- Fixed priority: en=1, rr_mode=0, y=4'b1010 held 3 cycles → a=3, valid=1, multi=1 each cycle. ptr unchanged (check via a following rr cycle with y=4'b0001 → a=0).
- Round-robin fairness: rr_mode=1, y=4'b1111 held 5 cycles from ptr=0 → a=0,1,2,3,0, multi=1 every cycle.
- Enable and zero requests: en=0 with y=4'b1000 → valid=0, a holds previous value. en=1, y=0 → valid=0, ptr unchanged (next y=4'b1111 resumes from the held ptr).
- Non-power-of-two wrap: N=5, rr_mode=1, y=5'b10001 for 3 cycles from reset → a=0,4,0. ptr never reaches 5–7.
- Async reset mid-stream: rr sequence in progress (ptr=2), pulse rst_n low between edges → outputs clear immediately. After release, y=4'b1111 → a=0.
